// File: rtl/alu_result_uart_tx.sv
// Serializes an N-bit ALU result onto a UART TX line as N/8 8N1 frames,
// most-significant byte first, each byte sent LSB first.
module alu_result_uart_tx #(
   parameter int unsigned N            = 16,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] result_in,
   input  logic         start,
   output logic         tx,
   output logic         busy,
   output logic         done
);

   localparam int unsigned NUM_BYTES = N / 8;
   localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W     = 3;

   generate
      if ((N % 8) != 0 || N < 8) begin : g_bad_width
         $error("alu_result_uart_tx: N must be a multiple of 8 and >= 8");
      end
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("alu_result_uart_tx: CLKS_PER_BIT must be >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA_BITS = 2'd2,
      STOP_BIT  = 2'd3
   } state_t;

   state_t             state;
   logic [N-1:0]       shift_reg;
   logic [6:0]         byte_sr;
   logic [BAUD_W-1:0]  baud_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [IDX_W-1:0]   byte_idx;
   logic               bit_end;
   logic               last_byte;

   // Current bit time ends on the last baud count; current byte always sits in the top 8 bits.
   always_comb begin
      bit_end   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
      last_byte = (byte_idx == IDX_W'(NUM_BYTES - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         shift_reg <= '0;
         byte_sr   <= '0;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         byte_idx  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (start && !busy) begin
                  shift_reg <= result_in;
                  byte_idx  <= '0;
                  bit_cnt   <= '0;
                  tx        <= 1'b0;
                  busy      <= 1'b1;
                  state     <= START_BIT;
               end
            end

            START_BIT: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  // Bit 0 goes straight to the line; bits 7..1 queue up in byte_sr.
                  tx       <= shift_reg[N-8];
                  byte_sr  <= shift_reg[N-1:N-7];
                  state    <= DATA_BITS;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            DATA_BITS: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == BIT_W'(7)) begin
                     tx    <= 1'b1;
                     state <= STOP_BIT;
                  end else begin
                     tx      <= byte_sr[0];
                     byte_sr <= byte_sr >> 1;
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            STOP_BIT: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (last_byte) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     // Next byte's start bit follows immediately, no idle gap.
                     byte_idx  <= byte_idx + IDX_W'(1);
                     shift_reg <= shift_reg << 8;
                     tx        <= 1'b0;
                     state     <= START_BIT;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx with N=16, CLKS_PER_BIT=4: cycle-exact
// tx waveform, byte decode, busy/done timing, ignored starts, chaining and reset.
module tb_alu_result_uart_tx;

   logic        clk;
   logic        rst;
   logic [15:0] result_in;
   logic        start;
   logic        tx;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   alu_result_uart_tx #(
      .N            (16),
      .CLKS_PER_BIT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .result_in (result_in),
      .start     (start),
      .tx        (tx),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Entered at the first negedge after the accept edge; walks all 80 bit cycles.
   task automatic check_word(input logic [7:0] eb0, input logic [7:0] eb1,
                             input bit poke_ignore, input bit chain,
                             input logic [15:0] next_w);
      logic [7:0] exp_b [2];
      logic [7:0] dec   [2];
      int         b, k, pos;
      logic       e;
      exp_b[0] = eb0;
      exp_b[1] = eb1;
      dec[0]   = 8'h00;
      dec[1]   = 8'h00;
      for (int c = 0; c < 80; c++) begin
         b   = c / 4;
         k   = b / 10;
         pos = b % 10;
         if (pos == 0)      e = 1'b0;
         else if (pos == 9) e = 1'b1;
         else               e = exp_b[k][pos-1];
         check_eq("tx_bit", 32'(tx), 32'(e));
         check_eq("busy_in_frame", 32'(busy), 32'd1);
         check_eq("done_early", 32'(done), 32'd0);
         if ((c % 4) == 2 && pos >= 1 && pos <= 8) dec[k][pos-1] = tx;
         start = poke_ignore && (c == 10 || c == 30);
         if (poke_ignore && c == 10) result_in = 16'hFFFF;
         @(negedge clk);
      end
      start = 1'b0;
      check_eq("done_pulse", 32'(done), 32'd1);
      check_eq("busy_at_done", 32'(busy), 32'd0);
      check_eq("tx_at_done", 32'(tx), 32'd1);
      check_eq("byte0", 32'(dec[0]), 32'(eb0));
      check_eq("byte1", 32'(dec[1]), 32'(eb1));
      if (chain) begin
         start     = 1'b1;
         result_in = next_w;
         @(negedge clk);
         start = 1'b0;
      end else begin
         @(negedge clk);
         check_eq("done_one_cycle", 32'(done), 32'd0);
      end
   endtask

   task automatic send(input logic [15:0] w);
      result_in = w;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      result_in = 16'h0000;

      // Reset state and idle line
      repeat (2) @(negedge clk);
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check_eq("idle_tx", 32'(tx), 32'd1);
         check_eq("idle_busy", 32'(busy), 32'd0);
      end

      // Single word A53C
      send(16'hA53C);
      check_word(8'hA5, 8'h3C, 1'b0, 1'b0, 16'h0000);

      // Signed shift result F800
      send(16'hF800);
      check_word(8'hF8, 8'h00, 1'b0, 1'b0, 16'h0000);

      // Starts while busy are ignored, as is result_in change
      send(16'h1234);
      check_word(8'h12, 8'h34, 1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("no_extra_done", 32'(done), 32'd0);
         check_eq("idle_after_ign", 32'(tx), 32'd1);
      end

      // Back-to-back: second start in the done cycle
      send(16'h0001);
      check_word(8'h00, 8'h01, 1'b0, 1'b1, 16'h8000);
      check_word(8'h80, 8'h00, 1'b0, 1'b0, 16'h0000);

      // Reset during DATA_BITS of byte 0
      send(16'hA53C);
      repeat (9) @(negedge clk);
      check_eq("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("midrst_tx", 32'(tx), 32'd1);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_done", 32'(done), 32'd0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check_eq("post_rst_done", 32'(done), 32'd0);
         check_eq("post_rst_tx", 32'(tx), 32'd1);
      end
      send(16'h00FF);
      check_word(8'h00, 8'hFF, 1'b0, 1'b0, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
